instruction_fetch_sequencer: RTL and testbench

Sequential fetch controller that sits directly upstream of the address register file. It drives the file's PC-select and PC-increment controls, reads a 16-bit little-endian instruction as two 8-bit memory bytes at PC and PC+1, and assembles the result into an instruction register. It presents that instruction to decode through a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/instruction_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_t : sequencer states (IDLE, FETCH_LO, FETCH_HI, VALID)
//   - FunSel codes understood by the address register file
//   - RegSel active-low enable patterns {PC, AR, SP}
//   - OutDSel code that routes PC onto OutD
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH_LO = 2'b01,
        FETCH_HI = 2'b10,
        VALID    = 2'b11
    } fetch_state_t;

    // Address register file function codes
    localparam logic [2:0] FETCH_FUNSEL_DEC  = 3'b000;
    localparam logic [2:0] FETCH_FUNSEL_INC  = 3'b001;
    localparam logic [2:0] FETCH_FUNSEL_LOAD = 3'b010;
    localparam logic [2:0] FETCH_FUNSEL_CLR  = 3'b011;
    // Code driven while no register is enabled; LOAD is harmless then
    localparam logic [2:0] FETCH_FUNSEL_IDLE = 3'b010;

    // Active-low register enables {PC, AR, SP}
    localparam logic [2:0] REGSEL_PC_ONLY = 3'b011;
    localparam logic [2:0] REGSEL_NONE    = 3'b111;

    // OutD source select: PC
    localparam logic [1:0] OUTDSEL_PC = 2'b00;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer
// Fetches a 16-bit little-endian instruction as two bytes at PC and PC+1,
// incrementing PC in the address register file once per accepted byte, and
// hands the assembled instruction to decode over a valid/ready handshake.
//
// Optional feature macro: FETCH_FLUSH_EN (adds i_flush; returns to IDLE and
// clears IR on the next edge, overriding MemWait and IRReady).
//
// Ports:
//   clk            in   system clock, rising-edge
//   rst_n          in   asynchronous active-low reset
//   i_flush        in   (FETCH_FLUSH_EN only) abandon current instruction
//   i_fetch_en     in   fetching permitted (level)
//   i_mem_wait     in   memory not ready; current fetch state holds
//   i_mem_data     in   byte at the address currently on ARF OutD
//   i_ir_ready     in   decode accepts the instruction
//   o_mem_read     out  memory read strobe
//   o_arf_outd_sel out  ARF OutD select (always PC)
//   o_arf_reg_sel  out  ARF active-low register enables {PC, AR, SP}
//   o_arf_fun_sel  out  ARF function code
//   o_ir           out  assembled instruction
//   o_ir_valid     out  IR holds a complete, unconsumed instruction
// -----------------------------------------------------------------------------
module instruction_fetch_sequencer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_FLUSH_EN
    input  logic        i_flush,
`endif
    input  logic        i_fetch_en,
    input  logic        i_mem_wait,
    input  logic [7:0]  i_mem_data,
    input  logic        i_ir_ready,
    output logic        o_mem_read,
    output logic [1:0]  o_arf_outd_sel,
    output logic [2:0]  o_arf_reg_sel,
    output logic [2:0]  o_arf_fun_sel,
    output logic [15:0] o_ir,
    output logic        o_ir_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [15:0]  r_ir;
    logic [15:0]  w_ir_next;
    logic         w_flush;

`ifdef FETCH_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // State and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
        end
    end

    // Next-state and outputs
    always_comb begin
        w_state_next   = r_state;
        w_ir_next      = r_ir;
        o_mem_read     = 1'b0;
        o_arf_outd_sel = OUTDSEL_PC;
        o_arf_reg_sel  = REGSEL_NONE;
        o_arf_fun_sel  = FETCH_FUNSEL_IDLE;
        o_ir_valid     = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_fetch_en) begin
                    w_state_next = FETCH_LO;
                end
            end

            FETCH_LO: begin
                o_mem_read    = 1'b1;
                o_arf_fun_sel = FETCH_FUNSEL_INC;
                // PC only advances on a cycle whose byte is actually taken;
                // a flush in this cycle means the byte is not taken either.
                if (!i_mem_wait && !w_flush) begin
                    o_arf_reg_sel   = REGSEL_PC_ONLY;
                    w_ir_next[7:0]  = i_mem_data;
                    w_state_next    = FETCH_HI;
                end
            end

            FETCH_HI: begin
                o_mem_read    = 1'b1;
                o_arf_fun_sel = FETCH_FUNSEL_INC;
                if (!i_mem_wait && !w_flush) begin
                    o_arf_reg_sel   = REGSEL_PC_ONLY;
                    w_ir_next[15:8] = i_mem_data;
                    w_state_next    = VALID;
                end
            end

            VALID: begin
                o_ir_valid = 1'b1;
                if (i_ir_ready) begin
                    w_state_next = i_fetch_en ? FETCH_LO : IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Flush overrides every other transition
        if (w_flush) begin
            w_state_next = IDLE;
            w_ir_next    = 16'h0000;
        end
    end

    assign o_ir = r_ir;

endmodule : instruction_fetch_sequencer

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_en;
    logic        mem_wait;
    logic [7:0]  mem_data;
    logic        ir_ready;
    logic        mem_read;
    logic [1:0]  outd_sel;
    logic [2:0]  reg_sel;
    logic [2:0]  fun_sel;
    logic [15:0] ir;
    logic        ir_valid;
`ifdef FETCH_FLUSH_EN
    logic        flush;
`endif

    instruction_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef FETCH_FLUSH_EN
        .i_flush        (flush),
`endif
        .i_fetch_en     (fetch_en),
        .i_mem_wait     (mem_wait),
        .i_mem_data     (mem_data),
        .i_ir_ready     (ir_ready),
        .o_mem_read     (mem_read),
        .o_arf_outd_sel (outd_sel),
        .o_arf_reg_sel  (reg_sel),
        .o_arf_fun_sel  (fun_sel),
        .o_ir           (ir),
        .o_ir_valid     (ir_valid)
    );

    // Environment: byte memory and the PC register of the address register file
    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_load_val;

    always @(posedge clk) begin
        if (pc_load)
            pc <= pc_load_val;
        else if (reg_sel == 3'b011 && fun_sel == 3'b001)
            pc <= pc + 16'd1;
    end

    assign mem_data = mem[pc];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        mem_wait    = 1'b0;
        ir_ready    = 1'b0;
`ifdef FETCH_FLUSH_EN
        flush       = 1'b0;
`endif
        pc_load     = 1'b1;
        pc_load_val = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        pc_load = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] v);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(negedge clk);
        pc_load     = 1'b0;
    endtask

    typedef struct {
        logic        fe, mw, rdy;
        logic        mr;
        logic [2:0]  rs, fs;
        logic        v;
        logic [15:0] ir;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] model_pc;
        logic [15:0] a1;
        logic [15:0] exp_ir;
        logic [15:0] held_ir;
        logic        hold_prev;
        int          handoffs;
        int          first_v;
        int          v_cnt;
        bit          got;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;

        // Each row: inputs for the cycle, outputs expected during that cycle
        //            fe    mw    rdy   mr    rs      fs      v     ir
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b010, 1'b0, 16'h0000}; // IDLE
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 3'b001, 1'b0, 16'h0000}; // LO wait
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 3'b001, 1'b0, 16'h0000}; // LO wait
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 3'b001, 1'b0, 16'h0000}; // LO take
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 3'b001, 1'b0, 16'h0034}; // HI take
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 16'h1234}; // VALID
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 16'h1234}; // hold
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 16'h1234}; // handoff
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b010, 1'b0, 16'h1234}; // parked

        // Reset state
        do_reset();
        #1;
        chk("reset_ir", 32'(ir), 32'h0000);
        chk("reset_valid", 32'(ir_valid), 32'h0);
        chk("reset_memread", 32'(mem_read), 32'h0);
        chk("reset_regsel", 32'(reg_sel), 32'h7);
        chk("reset_funsel", 32'(fun_sel), 32'h2);
        chk("reset_outdsel", 32'(outd_sel), 32'h0);

        // Table: fetch with two wait cycles in FETCH_LO, held VALID, park
        load_pc(16'h0100);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            fetch_en = tbl[i].fe;
            mem_wait = tbl[i].mw;
            ir_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_memread", i), 32'(mem_read), 32'(tbl[i].mr));
            chk($sformatf("row%0d_regsel", i), 32'(reg_sel), 32'(tbl[i].rs));
            chk($sformatf("row%0d_funsel", i), 32'(fun_sel), 32'(tbl[i].fs));
            chk($sformatf("row%0d_valid", i), 32'(ir_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d_ir", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("row%0d_outdsel", i), 32'(outd_sel), 32'h0);
            $display("table row %0d: fe=%0b mw=%0b rdy=%0b ir=%h valid=%0b pc=%h",
                     i, tbl[i].fe, tbl[i].mw, tbl[i].rdy, ir, ir_valid, pc);
        end
        chk("table_pc_after", 32'(pc), 32'h0102);

        // Back-to-back: one instruction every 3 cycles
        load_pc(16'h0100);
        first_v = -1;
        v_cnt   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            fetch_en = 1'b1;
            mem_wait = 1'b0;
            ir_ready = 1'b1;
            #1;
            if (ir_valid) begin
                v_cnt++;
                if (first_v < 0) first_v = c;
            end
        end
        chk("b2b_first_valid_cycle", 32'(first_v), 32'd3);
        chk("b2b_valid_count", 32'(v_cnt), 32'd3);
        $display("back-to-back: first valid at cycle %0d, %0d instructions in 10 cycles", first_v, v_cnt);

        // PC wrap: instruction straddles FFFF -> 0000
        do_reset();
        load_pc(16'hFFFF);
        @(negedge clk);
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (ir_valid) got = 1'b1;
        end
        chk("wrap_valid_seen", 32'(got), 32'h1);
        chk("wrap_ir", 32'(ir), 32'hABCD);
        chk("wrap_pc", 32'(pc), 32'h0001);
        $display("wrap fetch: ir=%h pc=%h", ir, pc);

        // Asynchronous reset in FETCH_HI discards the partial IR
        do_reset();
        load_pc(16'h0100);
        fetch_en = 1'b1;
        @(negedge clk);   // FETCH_LO after this edge
        @(negedge clk);   // FETCH_HI
        #1;
        chk("async_pre_lowbyte", 32'(ir), 32'h0034);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_ir", 32'(ir), 32'h0000);
        chk("async_valid", 32'(ir_valid), 32'h0);
        chk("async_regsel", 32'(reg_sel), 32'h7);
        chk("async_memread", 32'(mem_read), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk);
        #1;
        chk("async_parked_memread", 32'(mem_read), 32'h0);
        $display("async reset mid-fetch: ir=%h valid=%0b", ir, ir_valid);

`ifdef FETCH_FLUSH_EN
        // Flush during FETCH_HI
        do_reset();
        load_pc(16'h0200);
        fetch_en = 1'b1;
        @(negedge clk);   // FETCH_LO
        @(negedge clk);   // FETCH_HI
        flush = 1'b1;
        #1;
        chk("flush_hi_regsel", 32'(reg_sel), 32'h7);
        @(negedge clk);
        flush    = 1'b0;
        fetch_en = 1'b0;
        #1;
        chk("flush_valid", 32'(ir_valid), 32'h0);
        chk("flush_ir", 32'(ir), 32'h0000);
        chk("flush_memread", 32'(mem_read), 32'h0);
        chk("flush_pc", 32'(pc), 32'h0201);
        $display("flush in FETCH_HI: ir=%h pc=%h", ir, pc);
`endif

        // Randomized run against an instruction-level reference model
        do_reset();
        model_pc = 16'($urandom);
        load_pc(model_pc);
        handoffs  = 0;
        hold_prev = 1'b0;
        held_ir   = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            fetch_en = 1'b1;
            mem_wait = ($urandom_range(0, 3) == 0);
            ir_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (hold_prev) begin
                chk("rand_hold_valid", 32'(ir_valid), 32'h1);
                chk("rand_hold_ir", 32'(ir), 32'(held_ir));
            end
            if (ir_valid) begin
                chk("rand_valid_memread", 32'(mem_read), 32'h0);
                chk("rand_valid_regsel", 32'(reg_sel), 32'h7);
                if (ir_ready) begin
                    a1     = model_pc + 16'd1;
                    exp_ir = {mem[a1], mem[model_pc]};
                    model_pc = model_pc + 16'd2;
                    chk("rand_ir", 32'(ir), 32'(exp_ir));
                    chk("rand_pc", 32'(pc), 32'(model_pc));
                    handoffs++;
                    $display("rand handoff %0d: ir=%h expected=%h pc=%h", handoffs, ir, exp_ir, pc);
                end
            end
            hold_prev = ir_valid && !ir_ready;
            held_ir   = ir;
        end
        chk("rand_enough_handoffs", 32'(handoffs > 100), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instruction_fetch_sequencer
